// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port-A arbiter and its round-robin picker.
//   - default address/data widths and the largest supported requester count
//   - pipe_tag_t: {is_read, owner} carried alongside each accepted command
//   - idx_width(): width of a requester index (at least 1 bit)
package bram_arb_pkg;

  localparam int AW_DEF   = 11;
  localparam int DW_DEF   = 8;
  localparam int NREQ_MAX = 8;
  localparam int OWNER_W  = 3;

  typedef struct packed {
    logic               is_read;
    logic [OWNER_W-1:0] owner;
  } pipe_tag_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin priority picker.
// Searches req starting at last_grant+1 (wrapping modulo N) and reports the
// first set bit.
// Ports:
//   req        in  N   request vector
//   last_grant in  IW  index granted most recently
//   onehot     out N   one-hot winner (all zero when no request)
//   index      out IW  winner index (0 when no request)
//   valid      out 1   some request was found
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          valid
);

  // One extra bit so last_grant + k (up to 2N-1) never overflows before the wrap.
  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW:0] cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid                 = 1'b1;
        index                 = cand[IW-1:0];
        onehot[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM port A among NREQ requesters, one access per
// cycle, round-robin. The accepted command is registered onto the RAM port;
// read data comes back two cycles after accept, tagged with rvalid[owner].
// Optional macro BRAM_ARB_LOCK_EN: a requester granted last cycle that keeps
// req and req_lock high is granted again regardless of rotation.
// Ports:
//   clk, reset          clock / synchronous active-high reset
//   req, req_we         per-requester request and write flag
//   req_addr, req_wdata packed per-requester address / write data
//   req_lock            hold-grant request (only with BRAM_ARB_LOCK_EN)
//   ack                 combinational one-hot accept
//   rvalid, rdata       read return (rdata shared, qualified by rvalid)
//   ram_we/addr/di      registered command to BRAM port A
//   ram_spo             BRAM port A read data
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_lock,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_di,
  input  logic [DW-1:0]      ram_spo
);

  localparam int IW = idx_width(NREQ);

  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  logic [IW-1:0] last_grant_q, last_grant_d;
  logic          ram_we_q,     ram_we_d;
  logic [AW-1:0] ram_addr_q,   ram_addr_d;
  logic [DW-1:0] ram_di_q,     ram_di_d;
  pipe_tag_t     tag1_q,       tag1_d;
  pipe_tag_t     tag2_q;

  logic [NREQ-1:0] rr_onehot;
  logic [IW-1:0]   rr_index;
  logic            rr_valid;

  logic            win_valid;
  logic [IW-1:0]   win_index;
  logic [NREQ-1:0] win_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      // Stage-2 tag lines up with the cycle in which ram_spo holds the data.
      assign rvalid[gi]    = ~reset & tag2_q.is_read & (tag2_q.owner == OWNER_W'(gi));
    end
  endgenerate

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .onehot     (rr_onehot),
    .index      (rr_index),
    .valid      (rr_valid)
  );

`ifdef BRAM_ARB_LOCK_EN
  // granted_q: last_grant_q was actually granted in the previous cycle.
  logic granted_q;
  logic lock_hold;

  assign lock_hold  = granted_q & req[last_grant_q] & req_lock[last_grant_q];
  assign win_valid  = lock_hold | rr_valid;
  assign win_index  = lock_hold ? last_grant_q : rr_index;
  assign win_onehot = lock_hold ? (NREQ'(1) << last_grant_q) : rr_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      granted_q <= 1'b0;
    end else begin
      granted_q <= win_valid;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign win_valid   = rr_valid;
  assign win_index   = rr_index;
  assign win_onehot  = rr_onehot;
`endif

  assign ack = reset ? '0 : win_onehot;

  always_comb begin
    last_grant_d = last_grant_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_di_d     = ram_di_q;
    tag1_d       = '0;
    if (win_valid) begin
      last_grant_d  = win_index;
      ram_we_d      = req_we[win_index];
      ram_addr_d    = addr_arr[win_index];
      ram_di_d      = wdata_arr[win_index];
      tag1_d.is_read = ~req_we[win_index];
      tag1_d.owner   = OWNER_W'(win_index);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IW'(NREQ - 1);
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_di_q     <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_di_q     <= ram_di_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
    end
  end

  // A write registered just before reset must not reach the RAM while reset is high.
  assign ram_we   = ram_we_q & ~reset;
  assign ram_addr = ram_addr_q;
  assign ram_di   = ram_di_q;
  assign rdata    = ram_spo;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter (NREQ=2). Contains a behavioural BRAM for
// port A, a directed vector table, hand sequences for reset corner cases and
// a randomized phase checked against a transaction-level reference model.
module tb_bram_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 11;
  localparam int DW   = 8;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req, req_we, req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack, rvalid;
  logic [DW-1:0]      rdata;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_di;
  logic [DW-1:0]      ram_spo;

  bram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_lock  (req_lock),
    .ack       (ack),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .ram_spo   (ram_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h44;   // address 0x005 -> 0x41
  endfunction

  // Behavioural BRAM port A: write on the clock, registered address, read from it.
  logic [7:0]  mem [2048];
  logic [10:0] bram_addr_q;
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_di;
    end
    bram_addr_q <= ram_addr;
  end
  assign ram_spo = mem[bram_addr_q];

  // ---------------- reference model (transaction level) ----------------
  typedef struct { int due; int owner; logic [7:0] data; } rd_t;
  rd_t        rdq[$];
  logic [7:0] m_mem [2048];
  int         m_last;
  bit         m_prev_grant;
  logic       m_we;
  logic [10:0] m_addr;
  logic [7:0]  m_di;
  bit          m_pw_v;
  logic [10:0] m_pw_a;
  logic [7:0]  m_pw_d;
  int          cyc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rdq.delete();
    m_last       = NREQ - 1;
    m_prev_grant = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_di         = '0;
    m_pw_v       = 1'b0;   // a write registered before reset never lands
  endtask

  // Reset for two cycles with requests pending; checks reset-state outputs.
  task automatic do_reset();
    reset = 1'b1;
    req = 2'b11; req_we = 2'b00; req_lock = 2'b00;
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1; cyc++;
    @(negedge clk);
    chk("rst_ack2", 32'(ack), 32'h0);
    chk("rst_rvalid2", 32'(rvalid), 32'h0);
    chk("rst_ram_we2", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_di", 32'(ram_di), 32'h0);
    @(posedge clk); #1; cyc++;
    reset = 1'b0;
    req   = 2'b00;
    model_reset();
    $display("cyc %0d: reset released", cyc);
  endtask

  // One clock cycle: drive, predict, compare mid-cycle, advance.
  task automatic cycle(input logic [1:0] r, input logic [1:0] we, input logic [1:0] lk,
                       input logic [10:0] a0, input logic [10:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] tbl_ack, input bit use_tbl);
    int   w;
    logic [1:0]  exp_ack, exp_rv;
    logic [7:0]  exp_rd;
    logic [10:0] wa;
    logic [7:0]  wd;
    req = r; req_we = we; req_lock = lk;
    req_addr = {a1, a0}; req_wdata = {d1, d0};

    if (m_pw_v) begin
      m_mem[m_pw_a] = m_pw_d;
      m_pw_v = 1'b0;
    end

    w = -1;
`ifdef BRAM_ARB_LOCK_EN
    if (m_prev_grant && r[m_last] && lk[m_last]) w = m_last;
`endif
    if (w < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (w < 0 && r[c]) w = c;
      end
    end
    exp_ack = (w >= 0) ? 2'(1 << w) : 2'b00;

    exp_rv = 2'b00;
    exp_rd = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      exp_rv = 2'(1 << rdq[0].owner);
      exp_rd = rdq[0].data;
      void'(rdq.pop_front());
    end

    @(negedge clk);
    chk("ack", 32'(ack), 32'(exp_ack));
    if (use_tbl) chk("ack_tbl", 32'(ack), 32'(tbl_ack));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_addr", 32'(ram_addr), 32'(m_addr));
    chk("ram_di", 32'(ram_di), 32'(m_di));
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != 2'b00) chk("rdata", 32'(rdata), 32'(exp_rd));

    if (w >= 0) begin
      wa = (w == 0) ? a0 : a1;
      wd = (w == 0) ? d0 : d1;
      m_last = w;
      m_prev_grant = 1'b1;
      m_we = we[w];
      m_addr = wa;
      m_di = wd;
      if (we[w]) begin
        m_pw_v = 1'b1; m_pw_a = wa; m_pw_d = wd;
      end else begin
        rdq.push_back('{due: cyc + 2, owner: w, data: m_mem[wa]});
      end
      $display("cyc %0d: grant req%0d %s addr 0x%03h data 0x%02h", cyc, w,
               we[w] ? "write" : "read ", wa, we[w] ? wd : m_mem[wa]);
    end else begin
      m_prev_grant = 1'b0;
      m_we = 1'b0;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  r, we, lk;
    logic [10:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [1:0]  exp_ack;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] r, input logic [1:0] we, input logic [1:0] lk,
                     input logic [10:0] a0, input logic [10:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] ea);
    tbl.push_back('{r: r, we: we, lk: lk, a0: a0, a1: a1, d0: d0, d1: d1, exp_ack: ea});
  endtask

  function automatic logic [10:0] pick_addr();
    if ($urandom_range(1) == 0) return 11'($urandom_range(7));
    return 11'h7F8 + 11'($urandom_range(7));
  endfunction

  initial begin
    cyc = 0;
    reset = 1'b1; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 2048; i++) m_mem[i] = init_val(i);
    model_reset();

    // Read 0x005 (0x41), then 8 cycles of both requesting, alternating grants.
    add(2'b01, 2'b00, 2'b00, 11'h005, 11'h000, 8'h00, 8'h00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    add(2'b11, 2'b01, 2'b00, 11'h100, 11'h100, 8'h10, 8'h00, 2'b10);
    add(2'b11, 2'b01, 2'b00, 11'h100, 11'h100, 8'h10, 8'h00, 2'b01);
    add(2'b11, 2'b01, 2'b00, 11'h101, 11'h100, 8'h22, 8'h00, 2'b10);
    add(2'b11, 2'b01, 2'b00, 11'h101, 11'h101, 8'h22, 8'h00, 2'b01);
    add(2'b11, 2'b01, 2'b00, 11'h102, 11'h101, 8'h33, 8'h00, 2'b10);
    add(2'b11, 2'b01, 2'b00, 11'h102, 11'h102, 8'h33, 8'h00, 2'b01);
    add(2'b11, 2'b01, 2'b00, 11'h103, 11'h102, 8'h44, 8'h00, 2'b10);
    add(2'b11, 2'b01, 2'b00, 11'h103, 11'h103, 8'h44, 8'h00, 2'b01);
    // Write 0x7A to top address by req1, read it back by req0 next cycle.
    add(2'b10, 2'b10, 2'b00, 11'h000, 11'h7FF, 8'h00, 8'h7A, 2'b10);
    add(2'b01, 2'b00, 2'b00, 11'h7FF, 11'h000, 8'h00, 8'h00, 2'b01);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    // Only req1: five back-to-back reads.
    add(2'b10, 2'b00, 2'b00, 11'h000, 11'h005, 8'h00, 8'h00, 2'b10);
    add(2'b10, 2'b00, 2'b00, 11'h000, 11'h006, 8'h00, 8'h00, 2'b10);
    add(2'b10, 2'b00, 2'b00, 11'h000, 11'h007, 8'h00, 8'h00, 2'b10);
    add(2'b10, 2'b00, 2'b00, 11'h000, 11'h100, 8'h00, 8'h00, 2'b10);
    add(2'b10, 2'b00, 2'b00, 11'h000, 11'h7FF, 8'h00, 8'h00, 2'b10);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    // req0 holds req_lock for 4 cycles while req1 also requests.
`ifdef BRAM_ARB_LOCK_EN
    add(2'b11, 2'b00, 2'b01, 11'h010, 11'h020, 8'h00, 8'h00, 2'b01);
    add(2'b11, 2'b00, 2'b01, 11'h011, 11'h020, 8'h00, 8'h00, 2'b01);
    add(2'b11, 2'b00, 2'b01, 11'h012, 11'h020, 8'h00, 8'h00, 2'b01);
    add(2'b11, 2'b00, 2'b01, 11'h013, 11'h020, 8'h00, 8'h00, 2'b01);
    add(2'b11, 2'b00, 2'b00, 11'h014, 11'h020, 8'h00, 8'h00, 2'b10);
`else
    add(2'b11, 2'b00, 2'b01, 11'h010, 11'h020, 8'h00, 8'h00, 2'b01);
    add(2'b11, 2'b00, 2'b01, 11'h011, 11'h020, 8'h00, 8'h00, 2'b10);
    add(2'b11, 2'b00, 2'b01, 11'h012, 11'h020, 8'h00, 8'h00, 2'b01);
    add(2'b11, 2'b00, 2'b01, 11'h013, 11'h020, 8'h00, 8'h00, 2'b10);
    add(2'b11, 2'b00, 2'b00, 11'h014, 11'h020, 8'h00, 8'h00, 2'b01);
`endif
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 11'h000, 11'h000, 8'h00, 8'h00, 2'b00);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].we, tbl[i].lk, tbl[i].a0, tbl[i].a1,
            tbl[i].d0, tbl[i].d1, tbl[i].exp_ack, 1'b1);
    end

    // Reset the cycle after a read ack: the read must never return.
    cycle(2'b01, 2'b00, 2'b00, 11'h006, 11'h000, 8'h00, 8'h00, 2'b00, 1'b0);
    do_reset();
    idle(3);

    // Reset the cycle after a write ack: the write must not land.
    cycle(2'b10, 2'b10, 2'b00, 11'h000, 11'h010, 8'h00, 8'hEE, 2'b10, 1'b1);
    do_reset();
    cycle(2'b01, 2'b00, 2'b00, 11'h010, 11'h000, 8'h00, 8'h00, 2'b01, 1'b1);
    idle(3);

    // Randomized traffic with narrow address ranges to force hazards.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
      end else begin
        cycle(2'($urandom), 2'($urandom), 2'($urandom), pick_addr(), pick_addr(),
              8'($urandom), 8'($urandom), 2'b00, 1'b0);
      end
    end
    idle(3);
    chk("drain", 32'(rdq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single read/write port (port A) of the 2k x 8 dual-port BRAM among NREQ requesters, e.g. the host command path and the DSP/cosim path.
- Grants at most one access per cycle using round-robin priority.
- Registers the granted command onto the BRAM port.
- Returns read data to the originating requester tagged with a valid pulse. Port B (async-clock read) is untouched by this block.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 11, address width.
- DW, 8, data width.

Ports:
- clk  in  1  system clock; also drives BRAM port A clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- req  in  NREQ  per-requester access request; held until acked.
- req_we  in  NREQ  1 = write, 0 = read; stable while req high.
- req_addr  in  NREQ*AW  packed addresses; requester i at bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_lock  in  NREQ  hold-grant request (used only with feature; ignored otherwise).
- ack  out  NREQ  one-hot; combinational accept of the current request this cycle.
- rvalid  out  NREQ  one-hot; read data valid for requester i.
- rdata  out  DW  read data (shared bus; qualify with rvalid).
- ram_we  out  1  to BRAM we.
- ram_addr  out  AW  to BRAM a.
- ram_di  out  DW  to BRAM di.
- ram_spo  in  DW  from BRAM spo.

Behaviour:
- Reset values: ram_we=0, ram_addr=0, ram_di=0, rvalid=0, last_grant=NREQ-1 (so requester 0 wins first), in-flight pipeline flags cleared. ack=0 while reset is high.
- Arbitration (cycle N):
  - Winner = first requester with req=1, searching from last_grant+1 upward, modulo NREQ.
  - ack[winner]=1 in the same cycle; last_grant<=winner at the end of cycle N.
  - No requests: ack=0, last_grant unchanged.
- Command stage: at the edge ending cycle N, ram_we<=req_we[winner], ram_addr/ram_di<=winner's fields. With no winner, ram_we<=0 and addr/di hold.
  - ram_we is therefore high for exactly one cycle (N+1) per accepted write.
- Read return:
  - Pipeline registers carry {is_read, owner} through two stages.
  - BRAM captures the address at the end of N+1; spo is valid in N+2.
  - In N+2: rvalid[owner]=1, rdata=ram_spo. Accept-to-data latency is 2 cycles.
  - Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back reads from different requesters return in accept order with no gaps.
- Requester contract: after ack, the requester may change its fields or raise req again in the next cycle. A single active requester is granted every cycle.
- Read after write to the same address, accepted on consecutive cycles: the read returns the new data. The BRAM write occurs in N+1 and the read samples in N+2.
- Reset mid-operation: in-flight reads are discarded, with no rvalid in cycles following reset. Any command registered before reset is cleared, so no write lands after reset asserts.
- Unused/illegal: NREQ=1 degenerates to a registered passthrough. Do not instantiate with NREQ>8.

Optional Feature:
- Macro: BRAM_ARB_LOCK_EN.
- Defined:
  - If the requester granted in the previous cycle has req and req_lock both high, it wins again regardless of rotation.
  - Lock is released when req_lock or req drops; normal round-robin resumes from that requester.
- Undefined: req_lock is ignored; pure round-robin.

Decomposition:
- Package bram_arb_pkg:
  - Constants: default AW=11, DW=8, NREQ_MAX=8.
  - Typedef for the pipeline tag {is_read, owner[2:0]}.
- Sub-module rr_pick: a pure combinational round-robin priority picker with inputs req and last_grant, and outputs onehot and index. It is reused by future schedulers.
- The arbiter top holds all state.

Test Plan:
- Reset, then req[0] reads addr 0x005 (preloaded 0x41) -> ack[0] same cycle, ram_addr=0x005 next cycle, rvalid[0] with rdata=0x41 two cycles after ack.
- Both requesters hold req every cycle, 8 cycles -> acks alternate 0,1,0,1…; none starved; ram_we pulses match each write.
- req[1] writes 0x7A to 0x7FF, then req[0] reads 0x7FF the next cycle -> rvalid[0] with rdata=0x7A (wrap-top address).
- Only req[1] active for 5 reads -> ack[1] every cycle, 5 consecutive rvalid[1] in order.
- Reset asserted the cycle after a read ack -> no rvalid afterward; all outputs at reset values.
- With BRAM_ARB_LOCK_EN: req[0] holds req_lock for 4 cycles while req[1] also requests -> 4 consecutive acks to 0, then ack[1]. Without the macro, the same stimulus alternates.
